usrred: RTL and testbench
=========================

# usrred

Streaming reduction stage for the non-linear operator datapath. Consumes the signed WIDTH-bit element stream produced by the operand select mux and reduces one vector of a programmed length to a single value: either its sum (softmax/layernorm denominators) or its maximum (softmax max-subtraction). Valid/ready handshakes on input and output, one element per cycle, result held until taken downstream.

## Interface
- WIDTH, 64, element and result width, signed two's complement
- LEN_W, 16, width of the vector-length field
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- usrred_start  in  1  start pulse; sampled only in IDLE
- usrred_op  in  1  0 = sum, 1 = max; latched on accepted start
- usrred_len  in  LEN_W  element count of the vector; latched on accepted start
- usrred_i_valid  in  1  input element valid
- usrred_i_ready  out  1  stage accepts an element this cycle
- usrred_i  in  WIDTH  input element
- usrred_o_valid  out  1  result valid
- usrred_o_ready  in  1  downstream takes result
- usrred_o  out  WIDTH  reduction result
- usrred_busy  out  1  high in any state except IDLE
- usrred_ovf  out  1  sum overflowed during the current/last vector (see Configuration)

## Operation
- States IDLE, ACC, OUT.
- IDLE: i_ready=0, o_valid=0. On start with len>0: latch op and len, clear count, clear ovf, go ACC. On start with len=0: load acc with identity (0 for sum, -2^(WIDTH-1) for max), clear ovf, go OUT.
- ACC: i_ready=1. Each handshake (i_valid & i_ready): first element (count=0) loads acc=x; later elements acc=acc+x (sum) or acc=max(acc,x) signed (max). count increments. Handshake with count=len-1 goes OUT.
- OUT: i_ready=0, o_valid=1, o=acc, stable until o_valid & o_ready; then IDLE.
- start outside IDLE ignored; op/len changes outside accepted start ignored.
- Sum arithmetic: signed WIDTH-bit add; overflow when operand signs equal and result sign differs.
- usrred_o driven from acc register in all states; ovf sticky until next accepted start.

## Timing
- Reset (async assert, sync release): state IDLE, acc 0, count 0; i_ready 0, o_valid 0, o 0, busy 0, ovf 0.
- start in cycle T -> busy and i_ready high from T+1.
- Last element accepted in cycle T -> o_valid high from T+1.
- Throughput one element per cycle; minimum vector time len+2 cycles with o_ready held high.
- Result taken in cycle T -> IDLE at T+1; next start earliest at T+1.
- i_valid gaps stall ACC with no state change.
- rst_n asserted mid-vector: partial acc discarded, all outputs to reset values immediately.

## Configuration
- USRRED_SAT_EN defined: on sum overflow acc clamps to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative), ovf set; later elements accumulate from the clamped value.
- USRRED_SAT_EN undefined: sum wraps modulo 2^WIDTH; ovf still set on overflow. Max mode unaffected either way.

## Structure
- Shared package usrred_pkg: op encoding constants (OP_SUM, OP_MAX), state enum typedef, identity constants as functions of WIDTH.
- One sub-module usrred_alu: combinational sum/max with overflow detect and optional saturation; FSM, counter and registers stay in usrred.

## Test plan
- WIDTH=64, op=sum, len=4, elements 1,2,3,4 back-to-back, o_ready=1 -> o=10 one cycle after 4th handshake, ovf=0, busy low next cycle.
- op=max, len=3, elements -5,-2,-9 with one-cycle i_valid gaps -> o=-2, i_ready high throughout ACC.
- op=sum, len=2, elements 2^63-1 and 1 -> with USRRED_SAT_EN o=2^63-1, ovf=1; without o=-2^63, ovf=1.
- len=0 start, op=max -> o_valid at T+1 with o=-2^63; op=sum -> o=0.
- Result held with o_ready=0 for 5 cycles, start pulsed meanwhile -> o stable, start ignored, IDLE only after o_ready handshake.
- rst_n asserted after 2 of 4 elements -> i_ready, o_valid, busy, ovf, o all 0 immediately; fresh vector 7,8 sum -> 15.

Source files
------------

// File: rtl/usrred_pkg.sv
// rtl/usrred_pkg.sv - shared op encodings, state type and identity helper for usrred
package usrred_pkg;

    localparam int ID_W = 128;

    localparam logic OP_SUM = 1'b0;
    localparam logic OP_MAX = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    // Reduction identity for a w-bit signed element: 0 for sum, most negative value for max.
    // Callers truncate the result to their own width.
    function automatic logic [ID_W-1:0] identity(input logic op, input int w);
        return (op == OP_MAX) ? ({ID_W{1'b1}} << (w - 1)) : '0;
    endfunction

endpackage

// File: rtl/usrred_if.sv
// rtl/usrred_if.sv - start/element/result handshake bundle of the usrred reduction stage
interface usrred_if #(
    parameter int WIDTH = 64,
    parameter int LEN_W = 16
);
    logic             usrred_start;
    logic             usrred_op;
    logic [LEN_W-1:0] usrred_len;
    logic             usrred_i_valid;
    logic             usrred_i_ready;
    logic [WIDTH-1:0] usrred_i;
    logic             usrred_o_valid;
    logic             usrred_o_ready;
    logic [WIDTH-1:0] usrred_o;
    logic             usrred_busy;
    logic             usrred_ovf;

    modport master (
        output usrred_start, usrred_op, usrred_len, usrred_i_valid, usrred_i, usrred_o_ready,
        input  usrred_i_ready, usrred_o_valid, usrred_o, usrred_busy, usrred_ovf
    );

    modport slave (
        input  usrred_start, usrred_op, usrred_len, usrred_i_valid, usrred_i, usrred_o_ready,
        output usrred_i_ready, usrred_o_valid, usrred_o, usrred_busy, usrred_ovf
    );
endinterface

// File: rtl/usrred_alu.sv
// rtl/usrred_alu.sv - combinational sum/max step with overflow detect
// USRRED_SAT_EN: clamp sum on overflow instead of wrapping.
import usrred_pkg::*;

module usrred_alu #(
    parameter int WIDTH = 64
) (
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);

`ifdef USRRED_SAT_EN
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(identity(OP_MAX, WIDTH));
`endif

    logic [WIDTH-1:0] sum;

    always_comb begin
        sum = a + b;
        ovf = 1'b0;
        y   = a;
        if (op == OP_SUM) begin
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            y   = sum;
`ifdef USRRED_SAT_EN
            if (ovf) begin
                y = a[WIDTH-1] ? MIN_V : ~MIN_V;
            end
`endif
        end else if ($signed(b) > $signed(a)) begin
            y = b;
        end
    end

endmodule

// File: rtl/usrred.sv
// rtl/usrred.sv - streaming sum/max vector reduction stage with valid/ready handshakes
// USRRED_SAT_EN (in usrred_alu) selects saturating sum.
import usrred_pkg::*;

module usrred #(
    parameter int WIDTH = 64,
    parameter int LEN_W = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    usrred_if.slave  bus
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               op_q, op_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_ovf;

    usrred_alu #(.WIDTH(WIDTH)) u_alu (
        .op  (op_q),
        .a   (acc_q),
        .b   (bus.usrred_i),
        .y   (alu_y),
        .ovf (alu_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.usrred_start) begin
                    op_d  = bus.usrred_op;
                    ovf_d = 1'b0;
                    if (bus.usrred_len != '0) begin
                        len_d   = bus.usrred_len;
                        cnt_d   = '0;
                        state_d = S_ACC;
                    end else begin
                        acc_d   = WIDTH'(identity(bus.usrred_op, WIDTH));
                        state_d = S_OUT;
                    end
                end
            end
            S_ACC: begin
                if (bus.usrred_i_valid) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    // First element seeds the accumulator so max needs no identity preload
                    if (cnt_q == '0) begin
                        acc_d = bus.usrred_i;
                    end else begin
                        acc_d = alu_y;
                        ovf_d = ovf_q | alu_ovf;
                    end
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (bus.usrred_o_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            op_q    <= OP_SUM;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.usrred_i_ready = (state_q == S_ACC);
    assign bus.usrred_o_valid = (state_q == S_OUT);
    assign bus.usrred_o       = acc_q;
    assign bus.usrred_busy    = (state_q != S_IDLE);
    assign bus.usrred_ovf     = ovf_q;

endmodule

// File: tb/tb_usrred.sv
// tb/tb_usrred.sv - randomized scoreboard bench for usrred against a wide-integer reference model
module tb_usrred;

    localparam int WIDTH = 64;
    localparam int LEN_W = 16;
    localparam logic [63:0] MAXP = 64'h7fff_ffff_ffff_ffff;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic signed [127:0] MAXV = (128'sd1 <<< 63) - 128'sd1;
    localparam logic signed [127:0] MINV = -(128'sd1 <<< 63);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    usrred_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    usrred #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [63:0] o;
        logic        ovf;
    } exp_t;

    int tests = 0;
    int fails = 0;
    exp_t sb_q[$];
    logic [63:0] vec[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact arithmetic in 128 bits, overflow means leaving the 64-bit signed range
    function automatic void model(input logic op, output logic [63:0] r, output logic ovf);
        logic signed [127:0] acc;
        logic signed [127:0] t;
        logic signed [127:0] x;
        logic [63:0] tw;
        ovf = 1'b0;
        if (vec.size() == 0) begin
            r = op ? MINN : 64'd0;
            return;
        end
        acc = $signed(vec[0]);
        for (int k = 1; k < vec.size(); k++) begin
            x = $signed(vec[k]);
            if (op) begin
                if (x > acc) acc = x;
            end else begin
                t = acc + x;
                if (t > MAXV || t < MINV) begin
                    ovf = 1'b1;
`ifdef USRRED_SAT_EN
                    acc = (t > MAXV) ? MAXV : MINV;
`else
                    tw  = t[63:0];
                    acc = $signed(tw);
`endif
                end else begin
                    acc = t;
                end
            end
        end
        r = acc[63:0];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.usrred_o_valid && bus.usrred_o_ready) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %h expected none", bus.usrred_o);
            end else begin
                e = sb_q.pop_front();
                chk("result", bus.usrred_o, e.o);
                chk("ovf", {63'd0, bus.usrred_ovf}, {63'd0, e.ovf});
            end
        end
    end

    task automatic run_vector(input logic op, input int gap_max, input int hold, input bit poke_start);
        exp_t e;
        logic [63:0] r;
        logic ov;
        logic [63:0] held;
        int g;
        model(op, r, ov);
        e.o = r;
        e.ovf = ov;
        @(posedge clk); #1;
        bus.usrred_start = 1'b1;
        bus.usrred_op    = op;
        bus.usrred_len   = LEN_W'(vec.size());
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.usrred_start = 1'b0;
        bus.usrred_op    = ~op;
        bus.usrred_len   = LEN_W'($urandom);
        chk("busy_after_start", {63'd0, bus.usrred_busy}, 64'd1);
        foreach (vec[k]) begin
            g = $urandom_range(gap_max, 0);
            repeat (g) begin
                bus.usrred_i_valid = 1'b0;
                bus.usrred_i = {$urandom, $urandom};
                chk("i_ready_gap", {63'd0, bus.usrred_i_ready}, 64'd1);
                @(posedge clk); #1;
            end
            bus.usrred_i_valid = 1'b1;
            bus.usrred_i = vec[k];
            chk("i_ready_acc", {63'd0, bus.usrred_i_ready}, 64'd1);
            @(posedge clk); #1;
        end
        bus.usrred_i_valid = 1'b0;
        bus.usrred_i = {$urandom, $urandom};
        chk("o_valid_latency", {63'd0, bus.usrred_o_valid}, 64'd1);
        chk("i_ready_out", {63'd0, bus.usrred_i_ready}, 64'd0);
        held = bus.usrred_o;
        repeat (hold) begin
            if (poke_start) begin
                bus.usrred_start = 1'b1;
                bus.usrred_len = 16'd3;
            end
            @(posedge clk); #1;
            bus.usrred_start = 1'b0;
            chk("o_hold", bus.usrred_o, held);
            chk("o_valid_hold", {63'd0, bus.usrred_o_valid}, 64'd1);
        end
        bus.usrred_o_ready = 1'b1;
        @(posedge clk); #1;
        bus.usrred_o_ready = 1'b0;
        chk("busy_after_take", {63'd0, bus.usrred_busy}, 64'd0);
        chk("o_valid_after_take", {63'd0, bus.usrred_o_valid}, 64'd0);
    endtask

    function automatic logic [63:0] rand_elem();
        case ($urandom_range(3, 0))
            0: return {$urandom, $urandom};
            1: return 64'(int'($urandom_range(200, 0)) - 100);
            2: return MAXP - 64'($urandom_range(3, 0));
            default: return MINN + 64'($urandom_range(3, 0));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.usrred_start   = 1'b0;
        bus.usrred_op      = 1'b0;
        bus.usrred_len     = '0;
        bus.usrred_i_valid = 1'b0;
        bus.usrred_i       = '0;
        bus.usrred_o_ready = 1'b0;
        #12;
        chk("rst_i_ready", {63'd0, bus.usrred_i_ready}, 64'd0);
        chk("rst_o_valid", {63'd0, bus.usrred_o_valid}, 64'd0);
        chk("rst_busy", {63'd0, bus.usrred_busy}, 64'd0);
        chk("rst_ovf", {63'd0, bus.usrred_ovf}, 64'd0);
        chk("rst_o", bus.usrred_o, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        vec = {64'd1, 64'd2, 64'd3, 64'd4};
        run_vector(1'b0, 0, 0, 1'b0);
        vec = {-64'sd5, -64'sd2, -64'sd9};
        run_vector(1'b1, 1, 0, 1'b0);
        vec = {MAXP, 64'd1};
        run_vector(1'b0, 0, 1, 1'b0);
        vec = {};
        run_vector(1'b1, 0, 0, 1'b0);
        run_vector(1'b0, 0, 0, 1'b0);
        vec = {64'd100, -64'sd30, 64'd7};
        run_vector(1'b0, 0, 5, 1'b1);

        // Abort a vector after two elements, with overflow already flagged
        @(posedge clk); #1;
        bus.usrred_start = 1'b1;
        bus.usrred_op    = 1'b0;
        bus.usrred_len   = 16'd4;
        @(posedge clk); #1;
        bus.usrred_start = 1'b0;
        bus.usrred_i_valid = 1'b1;
        bus.usrred_i = MAXP;
        @(posedge clk); #1;
        bus.usrred_i = 64'd1;
        @(posedge clk); #1;
        bus.usrred_i_valid = 1'b0;
        chk("pre_rst_ovf", {63'd0, bus.usrred_ovf}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_i_ready", {63'd0, bus.usrred_i_ready}, 64'd0);
        chk("mid_rst_o_valid", {63'd0, bus.usrred_o_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, bus.usrred_busy}, 64'd0);
        chk("mid_rst_ovf", {63'd0, bus.usrred_ovf}, 64'd0);
        chk("mid_rst_o", bus.usrred_o, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        vec = {64'd7, 64'd8};
        run_vector(1'b0, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            vec = {};
            for (int k = 0; k < int'($urandom_range(8, 0)); k++) begin
                vec.push_back(rand_elem());
            end
            run_vector(1'($urandom_range(1, 0)), 2, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end

        @(posedge clk); #1;
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
